// File: rtl/present_byte_io.sv
// Byte-stream wrapper around the PRESENT-80 core: collects eight plaintext bytes,
// launches the core with a latched key, and drains the bit-order-corrected ciphertext.
module present_byte_io #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [79:0] key,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [63:0] core_state,
  output logic [79:0] core_keys,
  output logic        core_encrypt_start,
  input  logic        core_encrypt_end,
  input  logic [63:0] core_result,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {LOAD, START, DRAIN} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [63:0] pt_q, pt_d;
  logic [63:0] ct_q, ct_d;
  logic [63:0] core_state_q, core_state_d;
  logic [79:0] core_keys_q, core_keys_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  wd_q, wd_d;
  logic        timeout_err_q, timeout_err_d;
  logic [63:0] result_rev;

  // The core emits the ciphertext LSB-first; undo that once at capture.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_rev
      assign result_rev[gi] = core_result[63-gi];
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    pt_d          = pt_q;
    ct_d          = ct_q;
    core_state_d  = core_state_q;
    core_keys_d   = core_keys_q;
    cnt_d         = cnt_q;
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          pt_d  = {pt_q[55:0], in_data};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            core_state_d  = {pt_q[55:0], in_data};
            core_keys_d   = key;
            wd_d          = 8'd0;
            timeout_err_d = 1'b0;
            state_d       = START;
          end
        end
      end
      START: begin
        wd_d = wd_q + 8'd1;
        // A finishing core beats a simultaneous watchdog expiry.
        if (core_encrypt_end) begin
          ct_d    = result_rev;
          state_d = DRAIN;
        end else if (wd_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = LOAD;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          ct_d  = {ct_q[55:0], 8'h00};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= LOAD;
      pt_q          <= '0;
      ct_q          <= '0;
      core_state_q  <= '0;
      core_keys_q   <= '0;
      cnt_q         <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pt_q          <= pt_d;
      ct_q          <= ct_d;
      core_state_q  <= core_state_d;
      core_keys_q   <= core_keys_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign in_ready           = (state_q == LOAD);
  assign out_valid          = (state_q == DRAIN);
  assign out_data           = ct_q[63:56];
  assign core_state         = core_state_q;
  assign core_keys          = core_keys_q;
  assign core_encrypt_start = (state_q == START);
  assign busy               = (state_q == START) || (state_q == DRAIN);
  assign timeout_err        = timeout_err_q;

endmodule

// File: doc/present_byte_io.md
# present_byte_io

Byte-stream front end for the PRESENT-80 encryption core `p`: accepts 64-bit plaintext as eight bytes over a valid/ready stream and launches the core with a latched 80-bit key. Waits for `encrypt_end`, corrects the core's bit-reversed result ordering, and returns the 64-bit ciphertext as eight bytes over a second valid/ready stream. It sits directly upstream and downstream of `p`: it drives the core's inputs and consumes its `result`. A watchdog flags a core that never finishes.

## Interface

- TIMEOUT, 64: maximum cycles in START before abort; valid range 2..255.
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- key  in  80  cipher key, sampled on the 8th input byte handshake
- in_valid  in  1  plaintext byte valid
- in_data  in  8  plaintext byte, MSB-first (first byte = plaintext[63:56])
- in_ready  out  1  block accepts a byte
- out_valid  out  1  ciphertext byte valid
- out_data  out  8  ciphertext byte, MSB-first (first byte = ciphertext[63:56])
- out_ready  in  1  consumer accepts a byte
- core_state  out  64  to `p.state`
- core_keys  out  80  to `p.keys`
- core_encrypt_start  out  1  to `p.encrypt_start`
- core_encrypt_end  in  1  from `p.encrypt_end`
- core_result  in  64  from `p.result`; core_result[i] = ciphertext[63-i]
- busy  out  1  high in START or DRAIN
- timeout_err  out  1  sticky abort flag, cleared on next launch

## Operation

- FSM states: LOAD, START, DRAIN.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready shifts in_data into pt[7:0] (pt <<= 8).
  - A 3-bit byte counter increments on each handshake.
  - On the 8th handshake:
    - core_state <= assembled pt.
    - core_keys <= key.
    - count <= 0.
    - timeout_err <= 0.
    - Go to START.
- START:
  - core_encrypt_start=1; core_state and core_keys held stable.
  - Watchdog counter increments each cycle.
  - If core_encrypt_end=1:
    - ct <= bit-reverse(core_result).
    - core_encrypt_start <= 0.
    - Go to DRAIN.
  - Else if watchdog == TIMEOUT-1:
    - core_encrypt_start <= 0.
    - timeout_err <= 1.
    - Go to LOAD; no output produced.
- DRAIN:
  - out_valid=1, out_data=ct[63:56].
  - On out_valid&out_ready: ct <<= 8, counter++.
  - On the 8th handshake go to LOAD.
  - out_data is held stable while out_ready=0.
- core_encrypt_end is ignored outside START.
- Key changes outside the 8th-byte cycle have no effect.
- in_ready=0 in START and DRAIN; input bytes offered then are not consumed.
- Byte counter wraps 7→0 on the completing handshake.

## Timing

- Reset values:
  - in_ready=1, out_valid=0, out_data=0.
  - core_state=0, core_keys=0.
  - core_encrypt_start=0, busy=0, timeout_err=0.
  - State LOAD, counters 0, partial plaintext discarded.
- Reset mid-operation (any state) forces the reset values the next cycle. core_encrypt_start drops, so the core is released.
- 8th input handshake in cycle T → core_encrypt_start=1 from T+1.
- core_encrypt_end first high in cycle E → core_encrypt_start=0 and out_valid=1 from E+1.
- First output byte takes at least 1 cycle after end; full drain is 8 cycles with out_ready held high.
- Last output handshake in cycle D → in_ready=1 from D+1.
- Back-to-back throughput: 8 + core latency + 1 + 8 cycles per block.
- core_encrypt_start is low for at least 9 cycles between launches (DRAIN plus LOAD), so the core always sees a clean rising edge.
- Timeout:
  - Launch at T+1 with no end → core_encrypt_start=0 and timeout_err=1 from T+1+TIMEOUT.
  - in_ready=1 from the same cycle.
- Simultaneous end and watchdog expiry in the same cycle: end wins, no error.

## Test plan

- Reset, then feed ff×8 with key all-ones and out_ready=1 → core sees state ffff_ffff_ffff_ffff, start high until end. Output bytes 33 33 dc d3 21 32 10 d2.
- Plaintext 00×8, key 0 → 55 79 c1 38 7b 22 84 45. Then plaintext ff×8, key 0 back-to-back → a1 12 ff c7 2f 68 41 7b. Core start has a low gap ≥9 cycles between launches.
- Randomized in_valid and out_ready gaps, plaintext 0, key all-ones → e7 2c 46 c0 f5 94 50 49. out_data stable while stalled; no byte duplicated or dropped.
- Core model never asserts end, TIMEOUT=64 → start drops and timeout_err=1 exactly 64 cycles after launch; no out_valid. Next launch clears timeout_err.
- sys_rst asserted after 5 input bytes, and separately after 3 output bytes → all outputs at reset values next cycle. Subsequent full block encrypts correctly using only new bytes.
- core_encrypt_end pulsed during LOAD and DRAIN → no state change, no capture.
